// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready in and out, immediate expansion,
// class flags, optional M decode, illegal flagging, flush and a WFI sleep state.
module decode_stage #(
  parameter int PC_W       = 32,
  parameter bit ENABLE_M   = 1'b0,
  parameter bit ENABLE_WFI = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  input  logic            wake,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rd_valid,
  output logic            out_rs1_valid,
  output logic            out_rs2_valid,
  output logic [31:0]     out_imm,
  output logic [3:0]      out_aluop,
  output logic            out_is_branch,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_muldiv,
  output logic            out_is_wfi,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INSTR_WFI   = 32'h1050_0073;

  typedef enum logic {ST_RUN, ST_SLEEP} state_e;

  typedef struct packed {
    logic branch;
    logic jal;
    logic jalr;
    logic load;
    logic store;
    logic muldiv;
    logic wfi;
    logic illegal;
  } flags_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_valid;
    logic            rs1_valid;
    logic            rs2_valid;
    logic [31:0]     imm;
    logic [3:0]      aluop;
    flags_t          flags;
  } bundle_t;

  state_e  state_q, state_d;
  logic    out_valid_q, out_valid_d;
  bundle_t bundle_q, bundle_d;
  bundle_t dec;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        dec_legal, use_rd, use_rs1, use_rs2;
  logic [31:0] dec_imm;
  logic [3:0]  dec_aluop;
  flags_t      dec_cls;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  assign imm_i = {{21{in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Opcode classification; anything not explicitly legal falls out as illegal.
  always_comb begin
    dec_legal = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_imm   = 32'h0;
    dec_aluop = 4'h0;
    dec_cls   = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        use_rd    = 1'b1;
        dec_imm   = imm_u;
      end
      OPC_JAL: begin
        dec_legal   = 1'b1;
        use_rd      = 1'b1;
        dec_imm     = imm_j;
        dec_cls.jal = 1'b1;
      end
      OPC_JALR: begin
        dec_legal    = (funct3 == 3'b000);
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        dec_imm      = imm_i;
        dec_cls.jalr = 1'b1;
      end
      OPC_BRANCH: begin
        dec_legal      = (funct3[2:1] != 2'b01);
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        dec_imm        = imm_b;
        dec_aluop      = {1'b1, funct3};
        dec_cls.branch = 1'b1;
      end
      OPC_LOAD: begin
        dec_legal    = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        dec_imm      = imm_i;
        dec_cls.load = 1'b1;
      end
      OPC_STORE: begin
        dec_legal     = !funct3[2] && (funct3[1:0] != 2'b11);
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec_imm       = imm_s;
        dec_cls.store = 1'b1;
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)
          dec_legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
          dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else
          dec_legal = 1'b1;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        dec_imm   = imm_i;
        dec_aluop = {(funct3 == 3'b101) & in_instr[30], funct3};
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (funct7 == 7'h00) begin
          dec_legal = 1'b1;
          dec_aluop = {1'b0, funct3};
        end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_legal = 1'b1;
          dec_aluop = {1'b1, funct3};
        end else if (funct7 == 7'h01 && ENABLE_M) begin
          dec_legal      = 1'b1;
          dec_aluop      = {1'b0, funct3};
          dec_cls.muldiv = 1'b1;
        end
      end
      OPC_MISC_MEM: dec_legal = 1'b1;
      OPC_SYSTEM: begin
        dec_legal   = ENABLE_WFI && (in_instr == INSTR_WFI);
        dec_cls.wfi = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal encodings carry only the pc and the illegal flag.
  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    if (dec_legal) begin
      dec.rd_valid  = use_rd && (rd != 5'd0);
      dec.rs1_valid = use_rs1;
      dec.rs2_valid = use_rs2;
      dec.rd        = dec.rd_valid ? rd : 5'd0;
      dec.rs1       = use_rs1 ? rs1 : 5'd0;
      dec.rs2       = use_rs2 ? rs2 : 5'd0;
      dec.imm       = dec_imm;
      dec.aluop     = dec_aluop;
      dec.flags     = dec_cls;
    end else begin
      dec.flags.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = ST_RUN;
    else if (state_q == ST_RUN && out_valid_q && out_ready && bundle_q.flags.wfi)
      state_d = ST_SLEEP;
    else if (state_q == ST_SLEEP && wake)
      state_d = ST_RUN;
  end

  // A held WFI bundle may drain, but nothing may follow it in.
  always_comb begin
    in_ready = (state_q == ST_RUN) &&
               (!out_valid_q || (out_ready && !bundle_q.flags.wfi));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = bundle_q.pc;
  assign out_rd        = bundle_q.rd;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_rd_valid  = bundle_q.rd_valid;
  assign out_rs1_valid = bundle_q.rs1_valid;
  assign out_rs2_valid = bundle_q.rs2_valid;
  assign out_imm       = bundle_q.imm;
  assign out_aluop     = bundle_q.aluop;
  assign out_is_branch = bundle_q.flags.branch;
  assign out_is_jal    = bundle_q.flags.jal;
  assign out_is_jalr   = bundle_q.flags.jalr;
  assign out_is_load   = bundle_q.flags.load;
  assign out_is_store  = bundle_q.flags.store;
  assign out_is_muldiv = bundle_q.flags.muldiv;
  assign out_is_wfi    = bundle_q.flags.wfi;
  assign out_illegal   = bundle_q.flags.illegal;

endmodule
